ram_ctrl: RTL and testbench



---
 rtl/ram_ctrl.sv | 133 +++++++++++++
 tb/tb_ram_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Initiator for a single-port RAM on a shared bidirectional bus: sequences we/en/addr/data with
// setup, strobe, hold and turnaround phases. Define RAM_CTRL_VERIFY_EN to add a write read-back check.
module ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_write_in,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [DATA_WIDTH-1:0] req_wdata_in,
  output logic                  rsp_valid_out,
  output logic [DATA_WIDTH-1:0] rsp_rdata_out,
  output logic                  err_out,
  output logic                  ram_we_out,
  output logic                  ram_en_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic [3:0]            dbg_state_out
);

  // Handshake: a request transfers on the rising edge where req_valid_in && req_ready_out;
  // rsp_valid_out is a single-cycle pulse with no back-pressure.
`ifdef RAM_CTRL_VERIFY_EN
  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_EN, R_SAMPLE, R_TURN, V_EN, V_SAMPLE, V_TURN
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_EN, R_SAMPLE, R_TURN
  } state_t;
`endif

  state_t                state_q, state_d;
  logic                  we_d, en_d, drive_d;
  logic                  drive_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;

  assign accept        = (state_q == IDLE) && req_valid_in;
  assign dbg_state_out = state_q;
  assign ram_data      = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  always_comb begin
    state_d       = state_q;
    req_ready_out = 1'b0;
    rsp_valid_out = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) state_d = req_write_in ? W_SETUP : R_ADDR;
      end
      W_SETUP:  state_d = W_STROBE;
      W_STROBE: state_d = W_HOLD;
`ifdef RAM_CTRL_VERIFY_EN
      W_HOLD:   state_d = V_EN;
      V_EN:     state_d = V_SAMPLE;
      V_SAMPLE: state_d = V_TURN;
      V_TURN: begin
        rsp_valid_out = 1'b1;
        state_d       = IDLE;
      end
`else
      W_HOLD: begin
        rsp_valid_out = 1'b1;
        state_d       = IDLE;
      end
`endif
      R_ADDR:   state_d = R_EN;
      R_EN:     state_d = R_SAMPLE;
      R_SAMPLE: state_d = R_TURN;
      R_TURN: begin
        rsp_valid_out = 1'b1;
        state_d       = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // RAM pins are registered from the next state so they line up with the state they belong to.
  always_comb begin
    we_d    = (state_d == W_STROBE);
    drive_d = (state_d == W_SETUP) || (state_d == W_STROBE) || (state_d == W_HOLD);
`ifdef RAM_CTRL_VERIFY_EN
    en_d    = (state_d == R_EN) || (state_d == R_SAMPLE) ||
              (state_d == V_EN) || (state_d == V_SAMPLE);
`else
    en_d    = (state_d == R_EN) || (state_d == R_SAMPLE);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      ram_we_out    <= 1'b0;
      ram_en_out    <= 1'b0;
      ram_addr_out  <= '0;
      drive_q       <= 1'b0;
      wdata_q       <= '0;
      rsp_rdata_out <= '0;
    end else begin
      state_q    <= state_d;
      ram_we_out <= we_d;
      ram_en_out <= en_d;
      drive_q    <= drive_d;
      if (accept) begin
        ram_addr_out <= req_addr_in;
        wdata_q      <= req_wdata_in;
      end
      if (state_q == R_SAMPLE) rsp_rdata_out <= ram_data;
    end
  end

`ifdef RAM_CTRL_VERIFY_EN
  logic err_q;

  // Read-back compare against the word just written; sticky until reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      err_q <= 1'b0;
    end else if ((state_q == V_SAMPLE) && (ram_data != wdata_q)) begin
      err_q <= 1'b1;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: RAM model on a pulled-up bus, transaction-level timeline model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_ram_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
`ifdef RAM_CTRL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          req_valid_in = 1'b0;
  logic          req_write_in = 1'b0;
  logic [AW-1:0] req_addr_in = '0;
  logic [DW-1:0] req_wdata_in = '0;
  logic          req_ready_out, rsp_valid_out, err_out, ram_we_out, ram_en_out;
  logic [DW-1:0] rsp_rdata_out;
  logic [AW-1:0] ram_addr_out;
  logic [3:0]    dbg_state_out;
  wire  [DW-1:0] ram_data;

  ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_write_in(req_write_in), .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .rsp_valid_out(rsp_valid_out), .rsp_rdata_out(rsp_rdata_out), .err_out(err_out),
    .ram_we_out(ram_we_out), .ram_en_out(ram_en_out), .ram_addr_out(ram_addr_out),
    .ram_data(ram_data), .dbg_state_out(dbg_state_out)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  // Released bus reads back as all ones.
  pullup (ram_data);

  // RAM environment model
  logic [DW-1:0] mem [8];
  bit            stuck_bit0 = 1'b0;
  assign ram_data = (ram_en_out && !ram_we_out) ? mem[ram_addr_out] : {DW{1'bz}};
  always @(posedge clk_in)
    if (ram_we_out && !ram_en_out) mem[ram_addr_out] <= stuck_bit0 ? (ram_data & 8'hFE) : ram_data;

  // Scoreboard state
  int            n_cmp = 0;
  int            n_err = 0;
  int            edge_n = 0;
  int            ready_from = 0;
  int            last_acc = -1;
  int            last_rst = -1;
  bit            started = 1'b0;
  bit            op_valid = 1'b0;
  bit            op_write = 1'b0;
  int            op_ka = 0;
  logic [AW-1:0] op_addr = '0;
  logic [DW-1:0] op_wdata = '0;
  logic [DW-1:0] shadow [8];
  logic [AW-1:0] exp_addr = '0;
  bit            exp_err = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, edge_n);
    end
  endtask

  // Transaction model: decides acceptance from its own busy window.
  always @(posedge clk_in) begin
    int e;
    e = edge_n + 1;
    if (!rst_n_in) begin
      op_valid   = 1'b0;
      ready_from = e;
      exp_addr   = '0;
      exp_err    = 1'b0;
      exp_q.delete();
      last_rst   = e;
      started    = 1'b1;
    end else begin
      if (VER && op_valid && op_write && e == op_ka + 5 && shadow[op_addr] != op_wdata)
        exp_err = 1'b1;
      if (req_valid_in && (e - 1) >= ready_from) begin
        op_valid = 1'b1;
        op_write = req_write_in;
        op_ka    = e;
        op_addr  = req_addr_in;
        op_wdata = req_wdata_in;
        exp_addr = req_addr_in;
        last_acc = e;
        if (req_write_in) begin
          shadow[req_addr_in] = stuck_bit0 ? (req_wdata_in & 8'hFE) : req_wdata_in;
          ready_from = e + (VER ? 6 : 3);
        end else begin
          exp_q.push_back(shadow[req_addr_in]);
          ready_from = e + 4;
        end
      end
    end
    edge_n = e;
  end

  // Per-cycle compare against the timeline model.
  always @(negedge clk_in) begin
    int p, d;
    bit x_we, x_en, x_drv, x_rsp, x_rd;
    logic [DW-1:0] x_bus, x_rdata;
    if (started) begin
      p = edge_n;
      x_we = 0; x_en = 0; x_drv = 0; x_rsp = 0; x_rd = 0;
      if (op_valid) begin
        d = p - op_ka;
        if (op_write) begin
          x_drv = (d >= 0) && (d <= 2);
          x_we  = (d == 1);
          x_rsp = VER ? (d == 5) : (d == 2);
          x_en  = VER && (d == 3 || d == 4);
        end else begin
          x_en  = (d == 1) || (d == 2);
          x_rsp = (d == 3);
          x_rd  = x_rsp;
        end
      end
      x_bus = x_drv ? op_wdata : (x_en ? shadow[op_addr] : 8'hFF);
      check("ready", 32'(req_ready_out), 32'(p >= ready_from));
      check("we", 32'(ram_we_out), 32'(x_we));
      check("en", 32'(ram_en_out), 32'(x_en));
      check("we_en_excl", 32'(ram_we_out && ram_en_out), 32'd0);
      check("bus", 32'(ram_data), 32'(x_bus));
      check("addr", 32'(ram_addr_out), 32'(exp_addr));
      check("rsp_valid", 32'(rsp_valid_out), 32'(x_rsp));
      check("err", 32'(err_out), 32'(exp_err));
      if (p == last_rst) check("rdata_reset", 32'(rsp_rdata_out), 32'd0);
      if (x_rd) begin
        if (exp_q.size() == 0) begin
          check("rdata_queue_empty", 32'd1, 32'd0);
        end else begin
          x_rdata = exp_q.pop_front();
          check("rdata", 32'(rsp_rdata_out), 32'(x_rdata));
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_accept(output int k);
    k = -1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk_in);
      #1;
      if (last_acc == edge_n) begin
        k = edge_n;
        break;
      end
    end
    if (k < 0) check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] dat, output int k);
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_write_in = w;
    req_addr_in  = a;
    req_wdata_in = dat;
    wait_accept(k);
    @(negedge clk_in);
    req_valid_in = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  initial begin
    int k, prev;
    for (int i = 0; i < 8; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    rst_n_in = 1'b0;
    cycles(3);
    check("reset_ready", 32'(req_ready_out), 32'd1);
    check("reset_bus", 32'(ram_data), 32'hFF);
    rst_n_in = 1'b1;

    // Write 0xA5 to addr 3: data on bus three cycles, strobe in the middle one.
    send(1'b1, 3'd3, 8'hA5, k);
    check("w_setup_we", 32'(ram_we_out), 32'd0);
    check("w_setup_bus", 32'(ram_data), 32'hA5);
    cycles(1);
    check("w_strobe_we", 32'(ram_we_out), 32'd1);
    check("w_strobe_bus", 32'(ram_data), 32'hA5);
    cycles(1);
    check("w_hold_we", 32'(ram_we_out), 32'd0);
    check("w_hold_bus", 32'(ram_data), 32'hA5);
    check("w_hold_rsp", 32'(rsp_valid_out), VER ? 32'd0 : 32'd1);
    cycles(1);
    check("w_after_bus", 32'(ram_data), 32'hFF);
    check("w_after_ready", 32'(req_ready_out), VER ? 32'd0 : 32'd1);
    cycles(4);

    // Read addr 3 back.
    send(1'b0, 3'd3, 8'h00, k);
    check("r_addr_en", 32'(ram_en_out), 32'd0);
    check("r_addr_bus", 32'(ram_data), 32'hFF);
    cycles(1);
    check("r_en_en", 32'(ram_en_out), 32'd1);
    cycles(1);
    check("r_sample_en", 32'(ram_en_out), 32'd1);
    cycles(1);
    check("r_turn_en", 32'(ram_en_out), 32'd0);
    check("r_turn_rsp", 32'(rsp_valid_out), 32'd1);
    check("r_turn_rdata", 32'(rsp_rdata_out), 32'hA5);

    // Write 0x01..0x08 to addrs 0..7 with valid held continuously.
    @(negedge clk_in);
    req_valid_in = 1'b1; req_write_in = 1'b1; req_addr_in = 3'd0; req_wdata_in = 8'h01;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      wait_accept(k);
      if (prev >= 0) check("w_spacing", 32'(k - prev), VER ? 32'd7 : 32'd4);
      prev = k;
      @(negedge clk_in);
      if (i < 7) begin
        req_addr_in  = 3'(i + 1);
        req_wdata_in = 8'(i + 2);
      end else begin
        req_valid_in = 1'b0;
      end
    end

    // Read all eight back with valid held.
    @(negedge clk_in);
    req_valid_in = 1'b1; req_write_in = 1'b0; req_addr_in = 3'd0;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      wait_accept(k);
      if (prev >= 0) check("r_spacing", 32'(k - prev), 32'd5);
      prev = k;
      @(negedge clk_in);
      if (i < 7) req_addr_in = 3'(i + 1);
      else req_valid_in = 1'b0;
      cycles(3);
      check("r_seq_rdata", 32'(rsp_rdata_out), 32'(i + 1));
    end
    cycles(2);

    // Valid held while request fields change every cycle; only accept-edge values matter.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      req_valid_in = 1'b1;
      req_write_in = 1'($urandom_range(0, 1));
      req_addr_in  = 3'($urandom_range(0, 7));
      req_wdata_in = 8'($urandom_range(0, 254));
    end
    req_valid_in = 1'b0;
    cycles(10);

    // Reset during R_EN, then read the same address.
    send(1'b1, 3'd3, 8'h3C, k);
    cycles(4);
    send(1'b0, 3'd3, 8'h00, k);
    cycles(1);
    rst_n_in = 1'b0;
    cycles(1);
    check("rst_mid_we", 32'(ram_we_out), 32'd0);
    check("rst_mid_en", 32'(ram_en_out), 32'd0);
    check("rst_mid_bus", 32'(ram_data), 32'hFF);
    check("rst_mid_rsp", 32'(rsp_valid_out), 32'd0);
    rst_n_in = 1'b1;
    send(1'b0, 3'd3, 8'h00, k);
    cycles(3);
    check("rst_reread_rsp", 32'(rsp_valid_out), 32'd1);
    check("rst_reread_rdata", 32'(rsp_rdata_out), 32'h3C);
    cycles(2);

`ifdef RAM_CTRL_VERIFY_EN
    // Stuck-at-0 bit 0 makes the read-back of 0x01 fail.
    stuck_bit0 = 1'b1;
    send(1'b1, 3'd5, 8'h01, k);
    cycles(4);
    check("v_err_before", 32'(err_out), 32'd0);
    cycles(1);
    check("v_err_rise", 32'(err_out), 32'd1);
    check("v_rsp", 32'(rsp_valid_out), 32'd1);
    stuck_bit0 = 1'b0;
    cycles(2);
    send(1'b1, 3'd6, 8'h22, k);
    cycles(7);
    check("v_err_sticky", 32'(err_out), 32'd1);
    rst_n_in = 1'b0;
    cycles(2);
    rst_n_in = 1'b1;
    check("v_err_cleared", 32'(err_out), 32'd0);
`endif

    cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
